// File: rtl/mtm_alu_deserializer_n.sv
// Serial-input deserializer for the ALU.
// Receives 11-bit frames (start, type, 8 payload bits MSB first, stop) and
// assembles two DATA_W-bit operands and a 3-bit opcode. The block checks frame
// order, stop bits, a CRC4 over operands+opcode and the idle gap between the
// frames of a packet. Accepted packets and errors appear as one-cycle strobes
// on the edge after the deciding sample.
module mtm_alu_deserializer_n #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [2:0]        op_o,
    output logic              valid_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int BYTES       = DATA_W / 8;
    localparam int DATA_FRAMES = 2 * BYTES;
    localparam int CW          = $clog2(DATA_FRAMES + 1);
    localparam int TW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    // Frame count at which the control frame is expected.
    localparam logic [CW-1:0] CTRL_CNT = CW'(DATA_FRAMES);
    // Idle count at which one more idle cycle means a timeout.
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_DATA = 2'b01;
    localparam logic [1:0] ERR_CRC  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_SKIP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                state_reg,      state_next;
    logic [3:0]            bit_idx_reg,    bit_idx_next;
    logic [CW-1:0]         frame_cnt_reg,  frame_cnt_next;
    logic [2*DATA_W-1:0]   shift_reg,      shift_next;
    logic [3:0]            crc_reg,        crc_next;
    logic [3:0]            crc_rx_reg,     crc_rx_next;
    logic [2:0]            op_reg,         op_next;
    logic [TW-1:0]         idle_cnt_reg,   idle_cnt_next;
    logic                  valid_pend_reg, valid_pend_next;
    logic                  err_pend_reg,   err_pend_next;
    logic [1:0]            code_pend_reg,  code_pend_next;

    logic                  is_ctrl;

    // One step of the x^4+x+1 serial LFSR.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    assign is_ctrl = (frame_cnt_reg == CTRL_CNT);

    // Frame FSM: next state, datapath updates and pending strobe decisions.
    always_comb begin
        state_next      = state_reg;
        bit_idx_next    = bit_idx_reg;
        frame_cnt_next  = frame_cnt_reg;
        shift_next      = shift_reg;
        crc_next        = crc_reg;
        crc_rx_next     = crc_rx_reg;
        op_next         = op_reg;
        idle_cnt_next   = idle_cnt_reg;
        valid_pend_next = 1'b0;
        err_pend_next   = 1'b0;
        code_pend_next  = code_pend_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!sin) begin
                    state_next     = ST_RX;
                    bit_idx_next   = 4'd1;
                    frame_cnt_next = '0;
                    crc_next       = '0;
                    idle_cnt_next  = '0;
                end
            end

            ST_GAP: begin
                if (!sin) begin
                    state_next    = ST_RX;
                    bit_idx_next  = 4'd1;
                    idle_cnt_next = '0;
                end else if (TIMEOUT != 0) begin
                    if (idle_cnt_reg == TO_LAST) begin
                        err_pend_next  = 1'b1;
                        code_pend_next = ERR_TMO;
                        state_next     = ST_IDLE;
                        frame_cnt_next = '0;
                        crc_next       = '0;
                        idle_cnt_next  = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + TW'(1);
                    end
                end
            end

            ST_RX: begin
                bit_idx_next = bit_idx_reg + 4'd1;
                if (bit_idx_reg == 4'd1) begin
                    // Type bit must be 1 exactly when the control frame is due.
                    if (sin != is_ctrl) begin
                        err_pend_next  = 1'b1;
                        code_pend_next = ERR_DATA;
                        state_next     = ST_SKIP;
                        frame_cnt_next = '0;
                        crc_next       = '0;
                    end
                end else if (bit_idx_reg == 4'd10) begin
                    if (!sin) begin
                        // Bad stop bit; this 0 is not a new start bit.
                        err_pend_next  = 1'b1;
                        code_pend_next = ERR_DATA;
                        state_next     = ST_IDLE;
                        frame_cnt_next = '0;
                        crc_next       = '0;
                    end else if (!is_ctrl) begin
                        frame_cnt_next = frame_cnt_reg + CW'(1);
                        state_next     = ST_GAP;
                        idle_cnt_next  = '0;
                    end else begin
                        if (crc_reg == crc_rx_reg) begin
                            valid_pend_next = 1'b1;
                        end else begin
                            err_pend_next  = 1'b1;
                            code_pend_next = ERR_CRC;
                        end
                        state_next     = ST_IDLE;
                        frame_cnt_next = '0;
                        crc_next       = '0;
                    end
                end else if (!is_ctrl) begin
                    // Data payload: operands shift in MSB first, feed the CRC.
                    shift_next = {shift_reg[2*DATA_W-2:0], sin};
                    crc_next   = crc_step(crc_reg, sin);
                end else if (bit_idx_reg >= 4'd3 && bit_idx_reg <= 4'd5) begin
                    // Opcode bits are covered by the CRC; payload bit 7 is not.
                    op_next  = {op_reg[1:0], sin};
                    crc_next = crc_step(crc_reg, sin);
                end else if (bit_idx_reg >= 4'd6) begin
                    crc_rx_next = {crc_rx_reg[2:0], sin};
                end
            end

            ST_SKIP: begin
                bit_idx_next = bit_idx_reg + 4'd1;
                if (bit_idx_reg == 4'd10) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            bit_idx_reg    <= '0;
            frame_cnt_reg  <= '0;
            shift_reg      <= '0;
            crc_reg        <= '0;
            crc_rx_reg     <= '0;
            op_reg         <= '0;
            idle_cnt_reg   <= '0;
            valid_pend_reg <= 1'b0;
            err_pend_reg   <= 1'b0;
            code_pend_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            bit_idx_reg    <= bit_idx_next;
            frame_cnt_reg  <= frame_cnt_next;
            shift_reg      <= shift_next;
            crc_reg        <= crc_next;
            crc_rx_reg     <= crc_rx_next;
            op_reg         <= op_next;
            idle_cnt_reg   <= idle_cnt_next;
            valid_pend_reg <= valid_pend_next;
            err_pend_reg   <= err_pend_next;
            code_pend_reg  <= code_pend_next;
        end
    end

    // Output stage: strobes one edge after the decision; operands load with
    // valid_o. The shift register cannot change before the next frame's
    // payload, so it still holds the accepted operands here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_o        <= '0;
            b_o        <= '0;
            op_o       <= '0;
            valid_o    <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
        end else begin
            valid_o <= valid_pend_reg;
            err_o   <= err_pend_reg;
            if (err_pend_reg) begin
                err_code_o <= code_pend_reg;
            end
            if (valid_pend_reg) begin
                a_o  <= shift_reg[2*DATA_W-1:DATA_W];
                b_o  <= shift_reg[DATA_W-1:0];
                op_o <= op_reg;
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer_n.sv
// Bench for mtm_alu_deserializer_n: a 32-bit instance (TIMEOUT=16) and an
// 8-bit instance driven by directed packets. The packet model predicts each
// strobe and the held outputs; one compare process checks both DUTs per cycle.
module tb_mtm_alu_deserializer_n;

    localparam int TO32 = 16;
    localparam int TO8  = 256;

    localparam int F_NONE  = 0;
    localparam int F_CRC   = 1;
    localparam int F_TYPE  = 2;
    localparam int F_STOP  = 3;
    localparam int F_GAP   = 4;
    localparam int F_ABORT = 5;

    logic        clk = 1'b0;
    logic        rst32, rst8, sin32, sin8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [2:0]  op32, op8;
    logic        valid32, err32, valid8, err8;
    logic [1:0]  code32, code8;

    always #5 clk = ~clk;

    mtm_alu_deserializer_n #(.DATA_W(32), .TIMEOUT(TO32)) dut32 (
        .clk(clk), .rst(rst32), .sin(sin32), .a_o(a32), .b_o(b32), .op_o(op32),
        .valid_o(valid32), .err_o(err32), .err_code_o(code32)
    );

    mtm_alu_deserializer_n #(.DATA_W(8), .TIMEOUT(TO8)) dut8 (
        .clk(clk), .rst(rst8), .sin(sin8), .a_o(a8), .b_o(b8), .op_o(op8),
        .valid_o(valid8), .err_o(err8), .err_code_o(code8)
    );

    typedef struct {
        int          stamp;
        bit          is_err;
        logic [1:0]  code;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  op;
    } ev_t;

    ev_t         q32[$];
    ev_t         q8[$];
    logic [63:0] ea[2];
    logic [63:0] eb[2];
    logic [2:0]  eop[2];
    logic [1:0]  ecode[2];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Long division of message*x^4 by x^4+x+1, one message bit per call.
    function automatic logic [4:0] div_step(input logic [4:0] r, input logic bitv);
        logic [4:0] t;
        t = {r[3:0], bitv};
        if (t[4]) t = t ^ 5'b10011;
        return t;
    endfunction

    function automatic logic [3:0] model_crc(input int w, input logic [63:0] a,
                                              input logic [63:0] b, input logic [2:0] op);
        logic [4:0] r;
        r = '0;
        for (int i = w - 1; i >= 0; i--) r = div_step(r, a[i]);
        for (int i = w - 1; i >= 0; i--) r = div_step(r, b[i]);
        for (int i = 2; i >= 0; i--)     r = div_step(r, op[i]);
        for (int i = 0; i < 4; i++)      r = div_step(r, 1'b0);
        return r[3:0];
    endfunction

    task automatic push(input int d, input int stamp, input bit is_err, input logic [1:0] code,
                        input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        ev_t e;
        e.stamp = stamp; e.is_err = is_err; e.code = code; e.a = a; e.b = b; e.op = op;
        if (d == 0) q32.push_back(e); else q8.push_back(e);
    endtask

    // Drive one bit; e returns the number of the edge that samples it.
    task automatic drive_bit(input int d, input logic bv, output int e);
        @(negedge clk);
        if (d == 0) sin32 = bv; else sin8 = bv;
        e = cyc + 1;
    endtask

    task automatic idle(input int d, input int n);
        int e;
        for (int i = 0; i < n; i++) drive_bit(d, 1'b1, e);
    endtask

    // Sends one packet, optionally with a single fault, and records the outcome.
    task automatic send_packet(input int d, input logic [63:0] a, input logic [63:0] b,
                               input logic [2:0] op, input int fault, input int fidx,
                               input int gap_len);
        int         w, nb, nf, e, to;
        logic [3:0] crc;
        logic [7:0] pl;
        logic       tbit, stop;
        w  = (d == 0) ? 32 : 8;
        to = (d == 0) ? TO32 : TO8;
        nb = w / 8;
        nf = 2 * nb + 1;
        crc = model_crc(w, a, b, op);
        if (fault == F_CRC) crc[0] = ~crc[0];
        for (int f = 0; f < nf; f++) begin
            if (fault == F_GAP && f == fidx) begin
                for (int g = 0; g < gap_len; g++) begin
                    drive_bit(d, 1'b1, e);
                    if (g == to - 1) begin
                        push(d, e + 1, 1'b1, 2'b11, '0, '0, '0);
                        return;
                    end
                end
            end
            if (fault == F_ABORT && f == fidx) return;
            if (f < nb)           pl = a[8*(nb-1-f) +: 8];
            else if (f < 2 * nb)  pl = b[8*(2*nb-1-f) +: 8];
            else                  pl = {1'b0, op, crc};
            tbit = (f == nf - 1);
            if (fault == F_TYPE && f == fidx) tbit = ~tbit;
            drive_bit(d, 1'b0, e);
            drive_bit(d, tbit, e);
            if (fault == F_TYPE && f == fidx) begin
                push(d, e + 1, 1'b1, 2'b01, '0, '0, '0);
                for (int k = 7; k >= 0; k--) drive_bit(d, pl[k], e);
                drive_bit(d, 1'b1, e);
                return;
            end
            for (int k = 7; k >= 0; k--) drive_bit(d, pl[k], e);
            stop = !(fault == F_STOP && f == fidx);
            drive_bit(d, stop, e);
            if (!stop) begin
                push(d, e + 1, 1'b1, 2'b01, '0, '0, '0);
                return;
            end
            if (f == nf - 1) push(d, e + 1, fault == F_CRC, 2'b10, a, b, op);
        end
    endtask

    task automatic cmp_one(input int d);
        ev_t         e;
        bit          ev;
        logic        exp_v, exp_e;
        logic [63:0] act_a, act_b;
        ev = 1'b0;
        if (d == 0) begin
            if (q32.size() > 0 && q32[0].stamp <= cyc) begin e = q32.pop_front(); ev = 1'b1; end
            act_a = {32'b0, a32}; act_b = {32'b0, b32};
        end else begin
            if (q8.size() > 0 && q8[0].stamp <= cyc) begin e = q8.pop_front(); ev = 1'b1; end
            act_a = {56'b0, a8}; act_b = {56'b0, b8};
        end
        exp_v = ev && !e.is_err;
        exp_e = ev && e.is_err;
        if (ev) begin
            chk(d == 0 ? "w32_event_time" : "w8_event_time", 64'(e.stamp), 64'(cyc));
            if (e.is_err) ecode[d] = e.code;
            else begin ea[d] = e.a; eb[d] = e.b; eop[d] = e.op; end
        end
        if (d == 0) begin
            chk("w32_valid", 64'(valid32), 64'(exp_v));
            chk("w32_err",   64'(err32),   64'(exp_e));
            chk("w32_code",  64'(code32),  64'(ecode[0]));
            chk("w32_op",    64'(op32),    64'(eop[0]));
        end else begin
            chk("w8_valid", 64'(valid8), 64'(exp_v));
            chk("w8_err",   64'(err8),   64'(exp_e));
            chk("w8_code",  64'(code8),  64'(ecode[1]));
            chk("w8_op",    64'(op8),    64'(eop[1]));
        end
        chk(d == 0 ? "w32_a" : "w8_a", act_a, ea[d]);
        chk(d == 0 ? "w32_b" : "w8_b", act_b, eb[d]);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of both DUTs against the packet model.
    always @(posedge clk) begin
        #1;
        cmp_one(0);
        cmp_one(1);
    end

    task automatic clear_model(input int d);
        if (d == 0) q32.delete(); else q8.delete();
        ea[d] = '0; eb[d] = '0; eop[d] = '0; ecode[d] = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model(0);
        clear_model(1);
        rst32 = 1'b0; rst8 = 1'b0; sin32 = 1'b1; sin8 = 1'b1;
        repeat (3) @(negedge clk);
        rst32 = 1'b1; rst8 = 1'b1;
        idle(0, 2);

        // Reset state and model pins.
        chk("rst_a32", 64'(a32), 64'h0);
        chk("rst_b32", 64'(b32), 64'h0);
        chk("rst_code32", 64'(code32), 64'h0);
        chk("rst_strobes", 64'({valid32, err32, valid8, err8}), 64'h0);
        chk("crc_model_32", 64'(model_crc(32, 64'h1, 64'h2, 3'b100)), 64'h3);
        chk("crc_model_8", 64'(model_crc(8, 64'hA5, 64'h3C, 3'b001)), 64'h7);

        // Good packet, frames back-to-back.
        send_packet(0, 64'h1, 64'h2, 3'b100, F_NONE, 0, 0);
        idle(0, 3);
        chk("t1_a", 64'(a32), 64'h00000001);
        chk("t1_b", 64'(b32), 64'h00000002);
        chk("t1_op", 64'(op32), 64'h4);

        // CRC bit 0 flipped, then a good packet.
        send_packet(0, 64'h1, 64'h2, 3'b100, F_CRC, 0, 0);
        idle(0, 3);
        chk("t2_code", 64'(code32), 64'h2);
        chk("t2_a_held", 64'(a32), 64'h00000001);
        send_packet(0, 64'h12345678, 64'h9ABCDEF0, 3'b011, F_NONE, 0, 0);
        idle(0, 2);
        chk("t2_good_a", 64'(a32), 64'h12345678);

        // Control frame in place of the 3rd data frame, then a good packet.
        send_packet(0, 64'h1, 64'h2, 3'b100, F_TYPE, 2, 0);
        idle(0, 2);
        chk("t3_code", 64'(code32), 64'h1);
        send_packet(0, 64'hDEADBEEF, 64'h00FF00FF, 3'b110, F_NONE, 0, 0);
        idle(0, 2);
        chk("t3_good_b", 64'(b32), 64'h00FF00FF);

        // Data frame where the control frame is due.
        send_packet(0, 64'h5, 64'h6, 3'b010, F_TYPE, 8, 0);
        idle(0, 2);

        // Stop bit 0 in the 5th data frame, then back-to-back good packets.
        send_packet(0, 64'hCAFEF00D, 64'h1, 3'b001, F_STOP, 4, 0);
        idle(0, 2);
        send_packet(0, 64'hFFFFFFFF, 64'h80000000, 3'b111, F_NONE, 0, 0);
        send_packet(0, 64'h0F0F0F0F, 64'hF0F0F0F0, 3'b101, F_NONE, 0, 0);
        idle(0, 2);
        chk("t4_op", 64'(op32), 64'h5);

        // Gap of TIMEOUT-1 idle cycles accepted; TIMEOUT cycles time out.
        send_packet(0, 64'h11223344, 64'h55667788, 3'b010, F_GAP, 3, TO32 - 1);
        idle(0, 2);
        chk("t5_accept_a", 64'(a32), 64'h11223344);
        send_packet(0, 64'h1, 64'h2, 3'b100, F_GAP, 3, TO32);
        idle(0, 2);
        chk("t5_code", 64'(code32), 64'h3);
        send_packet(0, 64'hA0B0C0D0, 64'h01020304, 3'b000, F_NONE, 0, 0);
        idle(0, 2);

        // 8-bit instance: good packet, reset mid-packet, good packet.
        send_packet(1, 64'hA5, 64'h3C, 3'b001, F_NONE, 0, 0);
        idle(1, 2);
        chk("t6_a8", 64'(a8), 64'hA5);
        chk("t6_b8", 64'(b8), 64'h3C);
        send_packet(1, 64'h77, 64'h88, 3'b110, F_ABORT, 2, 0);
        @(negedge clk);
        rst8 = 1'b0;
        clear_model(1);
        idle(1, 3);
        rst8 = 1'b1;
        idle(1, 2);
        chk("t6_rst_a8", 64'(a8), 64'h0);
        chk("t6_rst_op8", 64'(op8), 64'h0);
        send_packet(1, 64'hA5, 64'h3C, 3'b001, F_NONE, 0, 0);
        idle(1, 3);
        chk("t6_after_rst_a8", 64'(a8), 64'hA5);

        idle(0, 4);
        chk("q32_drained", 64'(q32.size()), 64'h0);
        chk("q8_drained", 64'(q8.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtm_alu_deserializer_n.md
# mtm_alu_deserializer_n

Parametrised serial-input deserializer for the ALU. It receives 11-bit UART-style frames on `sin` and assembles two DATA_W-bit operands plus a 3-bit opcode. It checks frame sequencing, stop bits, CRC4 and inter-frame idle timeout. Successful packets and errors are reported as one-cycle strobes to the ALU core.

## Interface
- DATA_W, 32: operand width in bits; a multiple of 8, range 8..64; BYTES = DATA_W/8.
- TIMEOUT, 256: maximum consecutive idle cycles (`sin`=1) between frames inside a packet; 0 disables the check.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- sin  in  1  serial input; idle high; one bit per clock.
- a_o  out  DATA_W  operand A; the first DATA_W received bits, MSB first.
- b_o  out  DATA_W  operand B.
- op_o  out  3  opcode from the control frame.
- valid_o  out  1  one-cycle strobe: a_o/b_o/op_o hold a newly accepted packet.
- err_o  out  1  one-cycle strobe: packet rejected.
- err_code_o  out  2  01 = DATA (framing/sequence), 10 = CRC, 11 = TIMEOUT; holds its last value between strobes.

## Operation
- Frame: start bit 0, type bit (0 = data, 1 = control), 8 payload bits MSB first, stop bit 1.
- Packet structure:
  - 2*BYTES data frames: the first BYTES frames form A, the next BYTES frames form B; each is MSB-byte first, shifted in.
  - Then 1 control frame with payload {1'b0, op[2:0], crc[3:0]}.
- CRC4:
  - Polynomial x^4+x+1, init 4'b0000, serial LFSR, no reflection, no final XOR.
  - Input bits: the 2*DATA_W operand bits, then the 3 op bits, in arrival order.
  - The result is compared with crc[3:0].
- FSM states:
  - IDLE: frame count 0; `sin`=0 → RX, bit index 1.
  - RX: samples the type, payload and stop bits.
  - SKIP: consumes the remaining bits of a bad frame.
  - GAP: between frames of a packet; `sin`=0 → RX; otherwise the timeout counter increments.
- Sequence checks, at bit index 1 (type bit):
  - type=1 while data frames are still expected → ERR DATA, go to SKIP.
  - type=0 when the control frame is expected → ERR DATA, go to SKIP.
  - SKIP lasts until bit index 10, then goes to IDLE.
- Stop check: a stop bit of 0 → ERR DATA, go to IDLE immediately. The 0 on that cycle is not taken as a new start bit.
- Control-frame stop bit OK:
  - CRC match → load a_o/b_o/op_o, pulse valid_o.
  - CRC mismatch → ERR CRC; outputs unchanged.
  - Go to IDLE in both cases.
- Timeout: in GAP, when the idle counter reaches TIMEOUT → ERR TIMEOUT, go to IDLE. The counter clears on every start bit.
- Every error discards all partial operand, CRC and frame-count state. a_o/b_o/op_o change only on valid_o.
- Control-frame payload bit 7 is ignored. It is not checked.

## Timing
- Reset values: a_o=0, b_o=0, op_o=0, valid_o=0, err_o=0, err_code_o=00, FSM=IDLE, all counters 0.
- Reset deasserted mid-packet behaves as a fresh start; no strobe is emitted for the partial packet.
- Bit index 0 is the start bit, sampled at edge t0; bit index k is sampled at edge t0+k; the stop bit is at t0+10.
- valid_o/err_o (stop, CRC): registered on the edge after the stop-bit sample edge; high for exactly one cycle.
- valid_o/err_o (type error): registered on the edge after the type-bit sample; err_code_o updates on the same edge.
- Back-to-back frames: a start bit in the cycle directly after a stop bit is legal; GAP length may be 0.
- Timeout boundary:
  - A start bit sampled after TIMEOUT-1 idle cycles is accepted.
  - TIMEOUT consecutive idle cycles → err_o on the next edge.
- Throughput: one packet every 11*(2*BYTES+1) cycles minimum. valid_o and err_o are never high together.

## Test plan
- DATA_W=32: A=0x00000001, B=0x00000002, op=3'b100, correct CRC, frames back-to-back → valid_o pulses once; a_o=0x00000001, b_o=0x00000002, op_o=100; err_o stays 0.
- Same packet with the CRC bit 0 flipped → err_o pulse, err_code_o=10, valid_o=0; outputs keep their previous values. A following good packet is accepted.
- Control frame (type=1) sent as the 3rd frame → err_o, code 01, one cycle after the type bit. SKIP consumes 9 bits; a full good packet sent next is accepted.
- Stop bit forced to 0 in the 5th data frame → err_o, code 01; the next good packet is accepted.
- TIMEOUT=16: gap of 15 idle cycles → packet accepted; gap of 16 → err_o, code 11, and later frames start a new packet.
- DATA_W=8: A=0xA5, B=0x3C, op=3'b001 (3 frames total) → valid_o; a_o=0xA5, b_o=0x3C. Assert rst mid-packet → outputs 0 and no strobe.
